// File: rtl/cmp_sort4_ctrl.sv
// cmp_sort4_ctrl: sorts four nibbles with one shared 4-bit magnitude comparator, one compare-and-swap per clock.
// Optional CMP_SORT_EARLY_EXIT_EN ends the sort after the first pass that makes no swaps.

module cmp4_mag (
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  output logic       o_x_gt_y,
  output logic       o_x_lt_y,
  output logic       o_x_eq_y
);
  assign o_x_gt_y = (i_x > i_y);
  assign o_x_lt_y = (i_x < i_y);
  assign o_x_eq_y = (i_x == i_y);
endmodule

module cmp_sort4_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        desc,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        done,
  output logic [2:0]  swap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0][3:0] r_elem;
  logic            r_desc;
  logic [1:0]      r_p;
  logic [1:0]      r_k;
  logic [2:0]      r_swap_cnt;
  logic            r_busy;
  logic            r_done;
`ifdef CMP_SORT_EARLY_EXIT_EN
  logic            r_swap_flag;
`endif

  logic [1:0] w_k_next;
  logic [3:0] w_a;
  logic [3:0] w_b;
  logic       w_gt;
  logic       w_lt;
  logic       w_eq;
  logic       w_swap;
  logic       w_pass_end;
  logic       w_sort_end;

  assign w_k_next = r_k + 2'd1;
  assign w_a      = r_elem[r_k];
  assign w_b      = r_elem[w_k_next];

  cmp4_mag u_cmp (
    .i_x      (w_a),
    .i_y      (w_b),
    .o_x_gt_y (w_gt),
    .o_x_lt_y (w_lt),
    .o_x_eq_y (w_eq)
  );

  // Equal operands never swap, which keeps the sort stable.
  assign w_swap     = !w_eq && (r_desc ? w_lt : w_gt);
  assign w_pass_end = (r_k == (2'd2 - r_p));

`ifdef CMP_SORT_EARLY_EXIT_EN
  assign w_sort_end = w_pass_end && ((r_p == 2'd2) || !(r_swap_flag || w_swap));
`else
  assign w_sort_end = w_pass_end && (r_p == 2'd2);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      // NOTE: element registers are reset because data_out must read zero after reset.
      r_elem      <= '0;
      r_desc      <= 1'b0;
      r_p         <= 2'd0;
      r_k         <= 2'd0;
      r_swap_cnt  <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef CMP_SORT_EARLY_EXIT_EN
      r_swap_flag <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_elem      <= data_in;
            r_desc      <= desc;
            r_p         <= 2'd0;
            r_k         <= 2'd0;
            r_swap_cnt  <= 3'd0;
            r_busy      <= 1'b1;
            r_state     <= S_CMP;
`ifdef CMP_SORT_EARLY_EXIT_EN
            r_swap_flag <= 1'b0;
`endif
          end
        end
        S_CMP: begin
          if (w_swap) begin
            r_elem[r_k]      <= w_b;
            r_elem[w_k_next] <= w_a;
            r_swap_cnt       <= r_swap_cnt + 3'd1;
          end
          if (w_pass_end) begin
            r_p         <= r_p + 2'd1;
            r_k         <= 2'd0;
`ifdef CMP_SORT_EARLY_EXIT_EN
            r_swap_flag <= 1'b0;
`endif
          end else begin
            r_k         <= w_k_next;
`ifdef CMP_SORT_EARLY_EXIT_EN
            r_swap_flag <= r_swap_flag | w_swap;
`endif
          end
          if (w_sort_end) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = r_elem;
  assign busy     = r_busy;
  assign done     = r_done;
  assign swap_cnt = r_swap_cnt;

endmodule

// File: tb/tb_cmp_sort4_ctrl.sv
// Self-checking bench for cmp_sort4_ctrl: randomized and directed sorts against a counting-sort reference model.

module tb_cmp_sort4_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        desc;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        busy;
  logic        done;
  logic [2:0]  swap_cnt;

  int n_pass  = 0;
  int n_total = 0;

`ifdef CMP_SORT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  cmp_sort4_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .desc     (desc),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .swap_cnt (swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counting sort: smallest value lands in element 0 when ascending, element 3 when descending.
  function automatic logic [15:0] model_sort(input logic [15:0] d, input logic dsc);
    int          cnt [16];
    int          pos;
    logic [15:0] r;
    for (int v = 0; v < 16; v++) cnt[v] = 0;
    for (int i = 0; i < 4; i++) cnt[d[4*i +: 4]]++;
    pos = 0;
    r   = '0;
    for (int v = 0; v < 16; v++)
      for (int c = 0; c < cnt[v]; c++) begin
        if (dsc) r[4*(3-pos) +: 4] = 4'(v);
        else     r[4*pos +: 4]     = 4'(v);
        pos++;
      end
    return r;
  endfunction

  function automatic logic out_of_order(input logic [3:0] a, input logic [3:0] b, input logic dsc);
    return dsc ? (a < b) : (a > b);
  endfunction

  // Adjacent-swap sorting performs exactly one swap per inversion.
  function automatic int model_swaps(input logic [15:0] d, input logic dsc);
    int n = 0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (out_of_order(d[4*i +: 4], d[4*j +: 4], dsc)) n++;
    return n;
  endfunction

  // Passes that swap = largest count of out-of-order elements ahead of any element.
  function automatic int model_compares(input logic [15:0] d, input logic dsc);
    int worst = 0;
    int disp;
    for (int j = 1; j < 4; j++) begin
      disp = 0;
      for (int i = 0; i < j; i++)
        if (out_of_order(d[4*i +: 4], d[4*j +: 4], dsc)) disp++;
      if (disp > worst) worst = disp;
    end
    if (EARLY_EXIT && worst == 0) return 3;
    if (EARLY_EXIT && worst == 1) return 5;
    return 6;
  endfunction

  // Call at the negedge after the accepting edge; counts compare edges until done is seen.
  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic do_sort(input logic [15:0] d, input logic dsc, output int lat,
                         output logic [15:0] dout, output logic [2:0] sc,
                         output logic busy_at_done, output logic after_ok);
    @(negedge clk);
    data_in = d;
    desc    = dsc;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    dout         = data_out;
    sc           = swap_cnt;
    busy_at_done = busy;
    @(negedge clk);
    after_ok = (done === 1'b0) && (busy === 1'b0) && (data_out === dout);
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    start   = 1'b0;
    desc    = 1'b0;
    data_in = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (data_out !== 16'h0000) $display("FAIL reset_data_out got=%h exp=0000", data_out); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_total++; if (swap_cnt !== 3'd0) $display("FAIL reset_swap_cnt got=%0d exp=0", swap_cnt); else n_pass++;
  endtask

  task automatic test_directed;
    logic [15:0] vec_d   [3] = '{16'h1234, 16'h4321, 16'h5A5A};
    logic        vec_dsc [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] vec_exp [3] = '{16'h4321, 16'h4321, 16'h55AA};
    int          lat;
    logic [15:0] dout;
    logic [2:0]  sc;
    logic        bd;
    logic        ok;
    for (int t = 0; t < 3; t++) begin
      do_sort(vec_d[t], vec_dsc[t], lat, dout, sc, bd, ok);
      n_total++; if (dout !== vec_exp[t]) $display("FAIL directed%0d_data got=%h exp=%h", t, dout, vec_exp[t]); else n_pass++;
      n_total++; if (int'(sc) !== model_swaps(vec_d[t], vec_dsc[t])) $display("FAIL directed%0d_swaps got=%0d exp=%0d", t, sc, model_swaps(vec_d[t], vec_dsc[t])); else n_pass++;
      n_total++; if (lat !== model_compares(vec_d[t], vec_dsc[t])) $display("FAIL directed%0d_latency got=%0d exp=%0d", t, lat, model_compares(vec_d[t], vec_dsc[t])); else n_pass++;
      n_total++; if (bd !== 1'b1) $display("FAIL directed%0d_busy_at_done got=%b exp=1", t, bd); else n_pass++;
      n_total++; if (ok !== 1'b1) $display("FAIL directed%0d_after_done got=%b exp=1", t, ok); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [15:0] d;
    logic        dsc;
    int          lat;
    logic [15:0] dout;
    logic [2:0]  sc;
    logic        bd;
    logic        ok;
    for (int t = 0; t < 40; t++) begin
      d   = 16'($urandom);
      if (t % 4 == 0) d = model_sort(d, 1'b0);
      dsc = 1'($urandom_range(0, 1));
      do_sort(d, dsc, lat, dout, sc, bd, ok);
      n_total++; if (dout !== model_sort(d, dsc)) $display("FAIL random%0d_data in=%h desc=%b got=%h exp=%h", t, d, dsc, dout, model_sort(d, dsc)); else n_pass++;
      n_total++; if (int'(sc) !== model_swaps(d, dsc)) $display("FAIL random%0d_swaps in=%h got=%0d exp=%0d", t, d, sc, model_swaps(d, dsc)); else n_pass++;
      n_total++; if (lat !== model_compares(d, dsc)) $display("FAIL random%0d_latency in=%h got=%0d exp=%0d", t, d, lat, model_compares(d, dsc)); else n_pass++;
      n_total++; if ((bd & ok) !== 1'b1) $display("FAIL random%0d_handshake got=%b%b exp=11", t, bd, ok); else n_pass++;
    end
  endtask

  task automatic test_start_during_busy;
    int lat;
    @(negedge clk);
    data_in = 16'h1234;
    desc    = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    data_in = 16'hFFFF;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    n_total++; if (data_out !== 16'h4321) $display("FAIL busy_start_data got=%h exp=4321", data_out); else n_pass++;
    n_total++; if (swap_cnt !== 3'd6) $display("FAIL busy_start_swaps got=%0d exp=6", swap_cnt); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL busy_start_idle got=%b exp=0", busy); else n_pass++;
    n_total++; if (data_out !== 16'h4321) $display("FAIL busy_start_hold got=%h exp=4321", data_out); else n_pass++;
  endtask

  task automatic test_reset_mid_sort;
    int          lat;
    logic        saw_done;
    logic [15:0] dout;
    logic [2:0]  sc;
    logic        bd;
    logic        ok;
    @(negedge clk);
    data_in = 16'h1234;
    desc    = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL midreset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (data_out !== 16'h0000) $display("FAIL midreset_data got=%h exp=0000", data_out); else n_pass++;
    n_total++; if (swap_cnt !== 3'd0) $display("FAIL midreset_swaps got=%0d exp=0", swap_cnt); else n_pass++;
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    n_total++; if (saw_done !== 1'b0) $display("FAIL midreset_no_done got=%b exp=0", saw_done); else n_pass++;
    do_sort(16'h3A1C, 1'b1, lat, dout, sc, bd, ok);
    n_total++; if (dout !== model_sort(16'h3A1C, 1'b1)) $display("FAIL midreset_resort got=%h exp=%h", dout, model_sort(16'h3A1C, 1'b1)); else n_pass++;
    n_total++; if (int'(sc) !== model_swaps(16'h3A1C, 1'b1)) $display("FAIL midreset_resort_swaps got=%0d exp=%0d", sc, model_swaps(16'h3A1C, 1'b1)); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    data_in = 16'h2C7E;
    desc    = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(lat);
    n_total++; if (data_out !== model_sort(16'h2C7E, 1'b0)) $display("FAIL b2b_first got=%h exp=%h", data_out, model_sort(16'h2C7E, 1'b0)); else n_pass++;
    data_in = 16'h9B40;
    desc    = 1'b1;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_idle_gap got=%b exp=0", busy); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_restart got=%b exp=1", busy); else n_pass++;
    start = 1'b0;
    wait_done(lat);
    n_total++; if (data_out !== model_sort(16'h9B40, 1'b1)) $display("FAIL b2b_second got=%h exp=%h", data_out, model_sort(16'h9B40, 1'b1)); else n_pass++;
    n_total++; if (lat !== model_compares(16'h9B40, 1'b1)) $display("FAIL b2b_latency got=%0d exp=%0d", lat, model_compares(16'h9B40, 1'b1)); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_start_during_busy;
    test_reset_mid_sort;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
